// File: rtl/key_schedule_gen.sv
// key_schedule_gen: AES key expansion (FIPS-197) producing the full round-key
// schedule, one 32-bit word per clock, for Nk = 4/6/8 (Nr = 10/12/14).
// Optional feature: define KEY_SCHED_RESTART_EN to let a start during
// expansion abort the current run and restart with the new key; by default
// such a start is ignored.
// The schedule is packed with round 0 in the MSBs so it can feed the
// InverseCipher ik_sch input directly.

// Forward AES S-box as a combinational 256-entry lookup.
module aes_sbox (
    input  logic [7:0] a,
    output logic [7:0] y
);
    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    // Entry a lives at bit offset (255-a)*8, which is simply {~a, 3'b000}.
    assign y = SBOX[{~a, 3'b000} +: 8];
endmodule

module key_schedule_gen #(
    parameter int Nk = 4,
    parameter int Nr = 10
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [Nk*32-1:0]         key,
    output logic                     busy,
    output logic                     done,
    output logic                     sched_valid,
    output logic [(Nr+1)*128-1:0]    ik_sch
);
    localparam int NW = 4 * (Nr + 1);
    localparam int IW = $clog2(NW + 1);
    localparam int BW = $clog2(NW * 32);

    typedef enum logic [1:0] {IDLE, GEN, FIN} state_t;

    state_t        state;
    state_t        state_next;
    logic [IW-1:0] i;
    logic [7:0]    rcon;
    logic [7:0]    rcon_xtime;
    logic [31:0]   prev_word;
    logic [31:0]   old_word;
    logic [31:0]   sub_word;
    logic [31:0]   temp;
    logic [31:0]   new_word;
    logic [BW-1:0] prev_base;
    logic [BW-1:0] old_base;
    logic [BW-1:0] wr_base;
    logic          accept;
    logic          last_word;
    logic          rot_step;
    logic          sub_step;
    int            cur;
    int            md;

`ifdef KEY_SCHED_RESTART_EN
    assign accept = start && ((state == IDLE) || (state == GEN));
`else
    assign accept = start && (state == IDLE);
`endif

    assign busy       = (state != IDLE);
    assign last_word  = (i == IW'(NW - 1));
    assign rcon_xtime = {rcon[6:0], 1'b0} ^ (rcon[7] ? 8'h1b : 8'h00);

    // SubWord on w[i-1]; RotWord is applied afterwards since both are bytewise.
    aes_sbox u_sbox0 (.a(prev_word[31:24]), .y(sub_word[31:24]));
    aes_sbox u_sbox1 (.a(prev_word[23:16]), .y(sub_word[23:16]));
    aes_sbox u_sbox2 (.a(prev_word[15:8]),  .y(sub_word[15:8]));
    aes_sbox u_sbox3 (.a(prev_word[7:0]),   .y(sub_word[7:0]));

    // Locate w[i-1], w[i-Nk] and the write slot for w[i], then form the new word.
    always_comb begin
        cur       = (int'(i) < Nk) ? Nk : int'(i);
        md        = cur % Nk;
        rot_step  = (md == 0);
        sub_step  = (Nk == 8) && (md == 4);
        prev_base = BW'((NW - cur) * 32);
        old_base  = BW'((NW - 1 - cur + Nk) * 32);
        wr_base   = BW'((NW - 1 - cur) * 32);
        prev_word = ik_sch[prev_base +: 32];
        old_word  = ik_sch[old_base +: 32];
        if (rot_step) begin
            temp = {sub_word[23:0], sub_word[31:24]} ^ {rcon, 24'h0};
        end else if (sub_step) begin
            temp = sub_word;
        end else begin
            temp = prev_word;
        end
        new_word = old_word ^ temp;
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: one word per GEN cycle, then a single FIN cycle.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_next = GEN;
                end
            end
            GEN: begin
                if (accept) begin
                    state_next = GEN;
                end else if (last_word) begin
                    state_next = FIN;
                end
            end
            FIN: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Datapath: latch key on acceptance, append one word per GEN cycle, publish in FIN.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            i           <= '0;
            rcon        <= 8'h01;
            ik_sch      <= '0;
            done        <= 1'b0;
            sched_valid <= 1'b0;
        end else begin
            done <= 1'b0;
            if (accept) begin
                ik_sch[NW*32-1 -: Nk*32] <= key;
                i                        <= IW'(Nk);
                rcon                     <= 8'h01;
                sched_valid              <= 1'b0;
            end else if (state == GEN) begin
                ik_sch[wr_base +: 32] <= new_word;
                i                     <= i + IW'(1);
                if (rot_step) begin
                    rcon <= rcon_xtime;
                end
            end else if (state == FIN) begin
                done        <= 1'b1;
                sched_valid <= 1'b1;
            end
        end
    end
endmodule
